// File: rtl/commit_trace_tx.sv
// Commit trace producer: classifies each retiring instruction into a record,
// buffers the records in a small FIFO and streams them out as 16-bit words
// over a valid/ready handshake.
module commit_trace_tx #(
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [15:0] commit_pc,
  input  logic        reg_write,
  input  logic [2:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        halt,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] tx_data,
  output logic        tx_last,
  output logic        overflow,
  output logic        done,
  output logic [15:0] inst_count
);

  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [2:0] K_NOP  = 3'd0;
  localparam logic [2:0] K_REG  = 3'd1;
  localparam logic [2:0] K_LD   = 3'd2;
  localparam logic [2:0] K_STU  = 3'd3;
  localparam logic [2:0] K_ST   = 3'd4;
  localparam logic [2:0] K_HALT = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  // A record is stored already laid out as its output words plus a length,
  // so the serializer only has to walk an index.
  typedef struct packed {
    logic [2:0]  len;
    logic [15:0] w4;
    logic [15:0] w3;
    logic [15:0] w2;
    logic [15:0] w1;
    logic [15:0] w0;
  } rec_t;

  rec_t               mem [DEPTH];
  rec_t               new_rec;
  rec_t               rec_q;
  logic [2:0]         kind;

  logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q, rd_next;
  logic               fifo_empty, fifo_full, more_after_head;
  logic               accept, push, pop, load;
  logic [FIFO_AW-1:0] load_addr;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic               last_word, rec_is_halt;

  logic [15:0]        inst_count_q;
  logic               halted_q;
  logic               overflow_q;

  // Classify the retiring instruction and build its record image
  always_comb begin
    kind = K_NOP;
    if (halt)                        kind = K_HALT;
    else if (reg_write && mem_write) kind = K_STU;
    else if (reg_write && mem_read)  kind = K_LD;
    else if (reg_write)              kind = K_REG;
    else if (mem_write)              kind = K_ST;

    new_rec     = '0;
    new_rec.w0  = {kind, (reg_write ? write_reg : 3'd0), inst_count_q[9:0]};
    new_rec.w1  = commit_pc;
    new_rec.len = 3'd2;
    case (kind)
      K_REG: begin
        new_rec.w2  = write_data;
        new_rec.len = 3'd3;
      end
      K_LD: begin
        new_rec.w2  = write_data;
        new_rec.w3  = mem_addr;
        new_rec.len = 3'd4;
      end
      K_STU: begin
        new_rec.w2  = write_data;
        new_rec.w3  = mem_addr;
        new_rec.w4  = mem_data;
        new_rec.len = 3'd5;
      end
      K_ST: begin
        new_rec.w2  = mem_addr;
        new_rec.w3  = mem_data;
        new_rec.len = 3'd4;
      end
      default: ;
    endcase
  end

  // The record being serialized keeps its FIFO slot until its last word
  // leaves, so the FIFO depth bounds everything not yet fully transmitted.
  assign rd_next         = rd_ptr_q + 1'b1;
  assign fifo_empty      = (wr_ptr_q == rd_ptr_q);
  assign fifo_full       = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                           (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign more_after_head = (wr_ptr_q != rd_next);

  assign accept      = commit_valid && !halted_q;
  assign push        = accept && (!fifo_full || pop);
  assign last_word   = (idx_q == (rec_q.len - 3'd1));
  assign rec_is_halt = (rec_q.w0[15:13] == K_HALT);

  // Serializer next state: load headers, step word index, release slots
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    load      = 1'b0;
    load_addr = rd_ptr_q[FIFO_AW-1:0];
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          idx_d   = 3'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (last_word) begin
            pop = 1'b1;
            if (rec_is_halt) begin
              state_d = S_DONE;
            end else if (more_after_head) begin
              load      = 1'b1;
              load_addr = rd_next[FIFO_AW-1:0];
              idx_d     = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Record storage write port (no reset on the array itself)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[FIFO_AW-1:0]] <= new_rec;
  end

  // FSM, pointers, record register, counters and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      rec_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      inst_count_q <= 16'd0;
      halted_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) rec_q <= mem[load_addr];
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_next;
      if (accept) begin
        inst_count_q <= inst_count_q + 16'd1;
        if (halt) halted_q <= 1'b1;
        if (fifo_full && !pop) overflow_q <= 1'b1;
      end
    end
  end

  // Word select for the current record
  always_comb begin
    case (idx_q)
      3'd1:    tx_data = rec_q.w1;
      3'd2:    tx_data = rec_q.w2;
      3'd3:    tx_data = rec_q.w3;
      3'd4:    tx_data = rec_q.w4;
      default: tx_data = rec_q.w0;
    endcase
  end

  assign tx_valid   = (state_q == S_SEND);
  assign tx_last    = tx_valid && last_word;
  assign done       = (state_q == S_DONE);
  assign overflow   = overflow_q;
  assign inst_count = inst_count_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed testbench for commit_trace_tx.
module tb_commit_trace_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit_valid = 1'b0;
  logic [15:0] commit_pc = '0;
  logic        reg_write = 1'b0;
  logic [2:0]  write_reg = '0;
  logic [15:0] write_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_data = '0;
  logic        halt = 1'b0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        overflow;
  logic        done;
  logic [15:0] inst_count;

  int vectors = 0;
  int miscompares = 0;

  commit_trace_tx #(.FIFO_AW(3)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .halt(halt),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .overflow(overflow), .done(done),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    commit_valid = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drive one commit for exactly one cycle (call at posedge+1).
  task automatic commit(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                        input logic [15:0] wd, input logic mr, input logic mw,
                        input logic [15:0] ma, input logic [15:0] md, input logic h);
    commit_valid = 1'b1;
    commit_pc = pc; reg_write = rw; write_reg = wr; write_data = wd;
    mem_read = mr; mem_write = mw; mem_addr = ma; mem_data = md; halt = h;
    @(posedge clk); #1;
    commit_valid = 1'b0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; halt = 1'b0;
  endtask

  // Wait (bounded) for one word transfer and return it.
  task automatic recv_word(output logic [15:0] d, output logic l, output bit ok);
    ok = 1'b0;
    d = '0;
    l = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        d = tx_data;
        l = tx_last;
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors += 6;
    if (tx_valid !== 1'b0)      begin miscompares++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    if (tx_last !== 1'b0)       begin miscompares++; $display("FAIL reset_tx_last got %b want 0", tx_last); end
    if (tx_data !== 16'h0000)   begin miscompares++; $display("FAIL reset_tx_data got %h want 0000", tx_data); end
    if (overflow !== 1'b0)      begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    if (done !== 1'b0)          begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    if (inst_count !== 16'h0)   begin miscompares++; $display("FAIL reset_inst_count got %h want 0000", inst_count); end
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_reg();
    logic [15:0] exp [0:2];
    exp = '{16'h2C00, 16'h0002, 16'h1234};
    do_reset();
    tx_ready = 1'b1;
    commit(16'h0002, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reg_latency_n1 tx_valid got %b want 0", tx_valid); end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors += 3;
      if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL reg_valid[%0d] got %b want 1", k, tx_valid); end
      if (tx_data !== exp[k]) begin miscompares++; $display("FAIL reg_data[%0d] got %h want %h", k, tx_data, exp[k]); end
      if (tx_last !== (k == 2)) begin miscompares++; $display("FAIL reg_last[%0d] got %b want %b", k, tx_last, (k == 2)); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    vectors += 2;
    if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reg_end_valid got %b want 0", tx_valid); end
    if (inst_count !== 16'd1) begin miscompares++; $display("FAIL reg_inst_count got %0d want 1", inst_count); end
    $display("test_reg: REG record 2C00 0002 1234");
  endtask

  task automatic test_stu_stall();
    logic [15:0] exp [0:4];
    exp = '{16'h6400, 16'h0010, 16'h0011, 16'h0040, 16'hBEEF};
    do_reset();
    tx_ready = 1'b0;
    commit(16'h0010, 1'b1, 3'd1, 16'h0011, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors += 3;
      if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL stu_stall_valid[%0d] got %b want 1", k, tx_valid); end
      if (tx_data !== exp[k]) begin miscompares++; $display("FAIL stu_stall_data[%0d] got %h want %h", k, tx_data, exp[k]); end
      if (tx_last !== (k == 4)) begin miscompares++; $display("FAIL stu_stall_last[%0d] got %b want %b", k, tx_last, (k == 4)); end
      @(posedge clk); #1;
      tx_ready = 1'b1;
      @(negedge clk);
      vectors += 2;
      if (tx_data !== exp[k]) begin miscompares++; $display("FAIL stu_xfer_data[%0d] got %h want %h", k, tx_data, exp[k]); end
      if (tx_last !== (k == 4)) begin miscompares++; $display("FAIL stu_xfer_last[%0d] got %b want %b", k, tx_last, (k == 4)); end
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL stu_end_valid got %b want 0", tx_valid); end
    $display("test_stu_stall: STU record with alternating ready");
  endtask

  task automatic test_overflow();
    logic [15:0] want;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      commit(16'h0100 + 16'(i), 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    @(negedge clk);
    vectors += 2;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", overflow); end
    if (inst_count !== 16'd9) begin miscompares++; $display("FAIL ovf_inst_count got %0d want 9", inst_count); end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      want = (j % 2 == 0) ? 16'(j / 2) : (16'h0100 + 16'(j / 2));
      @(negedge clk);
      vectors += 3;
      if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid[%0d] got %b want 1", j, tx_valid); end
      if (tx_data !== want) begin miscompares++; $display("FAIL ovf_data[%0d] got %h want %h", j, tx_data, want); end
      if (tx_last !== (j % 2 == 1)) begin miscompares++; $display("FAIL ovf_last[%0d] got %b want %b", j, tx_last, (j % 2 == 1)); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    vectors += 2;
    if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_end_valid got %b want 0", tx_valid); end
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    $display("test_overflow: 9 commits, 8 records streamed back-to-back");
  endtask

  task automatic test_halt();
    logic [15:0] exp [0:5];
    logic [15:0] d;
    logic l;
    bit ok;
    exp = '{16'h5400, 16'h0020, 16'hCAFE, 16'h0080, 16'hE001, 16'h0021};
    do_reset();
    tx_ready = 1'b0;
    commit(16'h0020, 1'b1, 3'd5, 16'hCAFE, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b0);
    commit(16'h0021, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      commit(16'h0030 + 16'(i), 1'b1, 3'd2, 16'h7777, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    @(negedge clk);
    vectors += 2;
    if (done !== 1'b0) begin miscompares++; $display("FAIL halt_done_early got %b want 0", done); end
    if (inst_count !== 16'd2) begin miscompares++; $display("FAIL halt_inst_count got %0d want 2", inst_count); end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      recv_word(d, l, ok);
      vectors += 3;
      if (!ok) begin miscompares++; $display("FAIL halt_timeout[%0d] got none want word", k); end
      if (d !== exp[k]) begin miscompares++; $display("FAIL halt_data[%0d] got %h want %h", k, d, exp[k]); end
      if (l !== (k == 3 || k == 5)) begin miscompares++; $display("FAIL halt_last[%0d] got %b want %b", k, l, (k == 3 || k == 5)); end
    end
    @(negedge clk);
    vectors += 3;
    if (done !== 1'b1) begin miscompares++; $display("FAIL halt_done got %b want 1", done); end
    if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL halt_valid got %b want 0", tx_valid); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL halt_overflow got %b want 0", overflow); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    vectors += 3;
    if (done !== 1'b1) begin miscompares++; $display("FAIL halt_done_hold got %b want 1", done); end
    if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL halt_valid_hold got %b want 0", tx_valid); end
    if (inst_count !== 16'd2) begin miscompares++; $display("FAIL halt_inst_count_end got %0d want 2", inst_count); end
    $display("test_halt: LD then HALT, later commits ignored");
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    logic l;
    bit ok;
    do_reset();
    tx_ready = 1'b1;
    commit(16'h0030, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'h0044, 16'h5555, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    vectors += 2;
    if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid got %b want 1", tx_valid); end
    if (tx_data !== 16'h0044) begin miscompares++; $display("FAIL mid_pre_data got %h want 0044", tx_data); end
    rst = 1'b1;
    #1;
    vectors += 6;
    if (tx_valid !== 1'b0)    begin miscompares++; $display("FAIL mid_rst_valid got %b want 0", tx_valid); end
    if (tx_last !== 1'b0)     begin miscompares++; $display("FAIL mid_rst_last got %b want 0", tx_last); end
    if (tx_data !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_data got %h want 0000", tx_data); end
    if (overflow !== 1'b0)    begin miscompares++; $display("FAIL mid_rst_overflow got %b want 0", overflow); end
    if (done !== 1'b0)        begin miscompares++; $display("FAIL mid_rst_done got %b want 0", done); end
    if (inst_count !== 16'h0) begin miscompares++; $display("FAIL mid_rst_inst_count got %h want 0000", inst_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL mid_quiet[%0d] got %b want 0", i, tx_valid); end
      @(posedge clk); #1;
    end
    commit(16'h0031, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    recv_word(d, l, ok);
    vectors += 2;
    if (!ok || d !== 16'h0000) begin miscompares++; $display("FAIL mid_hdr got %h ok=%0d want 0000", d, ok); end
    if (l !== 1'b0) begin miscompares++; $display("FAIL mid_hdr_last got %b want 0", l); end
    recv_word(d, l, ok);
    vectors += 2;
    if (!ok || d !== 16'h0031) begin miscompares++; $display("FAIL mid_pc got %h ok=%0d want 0031", d, ok); end
    if (l !== 1'b1) begin miscompares++; $display("FAIL mid_pc_last got %b want 1", l); end
    $display("test_reset_mid: ST aborted by reset, NOP streamed after");
  endtask

  initial begin
    test_reset();
    test_reg();
    test_stu_stall();
    test_overflow();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
